// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - pipelined Rijndael ShiftRows/InvShiftRows engine, Nb = 4/6/8
//
// Purpose:
//   Applies ShiftRows (mode 00), InvShiftRows (mode 01) or a straight
//   pass-through (mode 10/11) to a 32*NB-bit state. It sits between SubBytes
//   and MixColumns. A sideband tag travels with each state, and valid/ready
//   handshakes on both sides let downstream round logic stall it.
//   Latency is 1 + REG_IN cycles, and throughput is one state per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input state valid
//   in_ready   block accepts input this cycle (no path from in_valid)
//   in_mode    00 forward, 01 inverse, 10/11 bypass
//   in_state   state, byte k at [32*NB-1-8k -: 8], s[r][c] = byte 4c+r
//   in_tag     sideband tag
//   out_valid  output valid
//   out_ready  downstream accepts
//   out_state  transformed state
//   out_tag    tag accepted with that state
//   busy       any pipeline stage holds valid data

module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int REG_IN = 0,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [32*NB-1:0]  in_state,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_state,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int W = 32 * NB;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Row r rotates left by this many columns. The 256-bit block skips offset 2.
  function automatic int row_off(input int r);
    if (NB == 8) begin
      return (r < 2) ? r : r + 1;
    end
    return r;
  endfunction

  // The permutation is pure byte wiring. The source column for each
  // destination byte is resolved at elaboration, so no arithmetic is built.
  function automatic logic [W-1:0] permute(input logic [W-1:0] s,
                                           input logic [1:0]   mode);
    logic [W-1:0] o;
    int           src_c;
    o = s;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (mode == 2'b00) begin
          src_c = (c + row_off(r)) % NB;
          o[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src_c+r) -: 8];
        end else if (mode == 2'b01) begin
          src_c = (c + NB - row_off(r)) % NB;
          o[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src_c+r) -: 8];
        end
      end
    end
    return o;
  endfunction

  // Feed into the output stage. It is the raw input when REG_IN=0, or the
  // input register when REG_IN=1.
  logic             pre_valid;
  logic [W-1:0]     pre_state;
  logic [TAG_W-1:0] pre_tag;
  logic             first_busy;

  // Output stage state
  logic             out_v_q, out_v_d;
  logic [W-1:0]     out_s_q, out_s_d;
  logic [TAG_W-1:0] out_t_q, out_t_d;
  logic             out_load;

  // The output stage may load when it is empty or when its content leaves this cycle.
  assign out_load = !out_v_q || out_ready;

  generate
    if (REG_IN != 0) begin : g_in_reg
      logic             in_v_q;
      logic [W-1:0]     in_s_q;
      logic [1:0]       in_m_q;
      logic [TAG_W-1:0] in_t_q;
      logic             in_adv;

      assign in_adv   = in_v_q && out_load;
      assign in_ready = !in_v_q || in_adv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_v_q <= 1'b0;
          in_s_q <= '0;
          in_m_q <= 2'b00;
          in_t_q <= '0;
        end else if (in_ready) begin
          in_v_q <= in_valid;
          // Mode is latched with the data, so later in_mode changes cannot
          // affect a state that is already in flight.
          if (in_valid) begin
            in_s_q <= in_state;
            in_m_q <= in_mode;
            in_t_q <= in_tag;
          end
        end
      end

      assign pre_valid  = in_v_q;
      assign pre_state  = permute(in_s_q, in_m_q);
      assign pre_tag    = in_t_q;
      assign first_busy = in_v_q;
    end else begin : g_no_in_reg
      assign in_ready   = out_load;
      assign pre_valid  = in_valid;
      assign pre_state  = permute(in_state, in_mode);
      assign pre_tag    = in_tag;
      assign first_busy = 1'b0;
    end
  endgenerate

  always_comb begin
    out_v_d = out_v_q;
    out_s_d = out_s_q;
    out_t_d = out_t_q;
    if (out_load) begin
      out_v_d = pre_valid;
      // Data registers load only with a valid beat. The last delivered state
      // stays visible instead of being overwritten by idle inputs.
      if (pre_valid) begin
        out_s_d = pre_state;
        out_t_d = pre_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q <= 1'b0;
      out_s_q <= '0;
      out_t_q <= '0;
    end else begin
      out_v_q <= out_v_d;
      out_s_q <= out_s_d;
      out_t_q <= out_t_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_state = out_s_q;
  assign out_tag   = out_t_q;
  assign busy      = out_v_q || first_busy;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - self-checking bench for shift_rows_pipe
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u_a: NB=4, REG_IN=1
  logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [1:0]   a_in_mode = 2'b00;
  logic [127:0] a_in_state = '0, a_out_state;
  logic [3:0]   a_in_tag = '0, a_out_tag;

  // u_b: NB=8, REG_IN=0
  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [1:0]   b_in_mode = 2'b00;
  logic [255:0] b_in_state = '0, b_out_state;
  logic [3:0]   b_in_tag = '0, b_out_tag;

  // u_c: NB=6, REG_IN=0
  logic         c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_busy;
  logic [1:0]   c_in_mode = 2'b00;
  logic [191:0] c_in_state = '0, c_out_state;
  logic [3:0]   c_in_tag = '0, c_out_tag;

  shift_rows_pipe #(.NB(4), .REG_IN(1), .TAG_W(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_state(a_in_state), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_state(a_out_state), .out_tag(a_out_tag), .busy(a_busy)
  );

  shift_rows_pipe #(.NB(8), .REG_IN(0), .TAG_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_state(b_in_state), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_state(b_out_state), .out_tag(b_out_tag), .busy(b_busy)
  );

  shift_rows_pipe #(.NB(6), .REG_IN(0), .TAG_W(4)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_mode(c_in_mode),
    .in_state(c_in_state), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_state(c_out_state), .out_tag(c_out_tag), .busy(c_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction through u_a with out_ready held high. Returns the result and
  // the latency, counted in edges from the accept edge to out_valid.
  task automatic xfer_a(input logic [1:0] mode, input logic [127:0] st, input logic [3:0] tag,
                        output logic [127:0] got_s, output logic [3:0] got_t, output int lat);
    logic rdy;
    logic accepted;
    accepted = 1'b0;
    got_s = '0;
    got_t = '0;
    lat = 0;
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_mode = mode;
    a_in_state = st;
    a_in_tag = tag;
    a_out_ready = 1'b1;
    for (int i = 0; i < 10 && !accepted; i++) begin
      #1;
      rdy = a_in_ready;
      @(posedge clk);
      if (rdy) accepted = 1'b1;
      else @(negedge clk);
    end
    #1;
    a_in_valid = 1'b0;
    a_in_mode = mode ^ 2'b01;
    a_in_state = ~st;
    if (!accepted) begin
      chk("xfer_accept_timeout", 0, 1);
    end else begin
      lat = 1;
      while (!a_out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      got_s = a_out_state;
      got_t = a_out_tag;
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] st;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [127:0] gs, gs2, rs;
    logic [3:0]   gt, gt2;
    int           lat, lat2;
    int           acc, emit_n, vcnt;
    logic [127:0] prev_s;
    logic [3:0]   prev_t;
    logic         prev_stall, exp_rdy, acc_now, em_now;
    int           exp_cyc[8];

    vecs[0] = '{2'b00, 128'h000102030405060708090a0b0c0d0e0f, 4'h3, 128'h00050a0f04090e03080d02070c01060b};
    vecs[1] = '{2'b01, 128'h00050a0f04090e03080d02070c01060b, 4'h5, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[2] = '{2'b10, 128'h00112233445566778899aabbccddeeff, 4'h9, 128'h00112233445566778899aabbccddeeff};
    vecs[3] = '{2'b11, 128'h00112233445566778899aabbccddeeff, 4'ha, 128'h00112233445566778899aabbccddeeff};
    vecs[4] = '{2'b01, 128'h000102030405060708090a0b0c0d0e0f, 4'hf, 128'h000d0a0704010e0b0805020f0c090603};
    vecs[5] = '{2'b00, 128'h00112233445566778899aabbccddeeff, 4'h1, 128'h0055aaff4499ee3388dd2277cc1166bb};
    exp_cyc = '{2, 7, 8, 9, 10, 11, 12, 13};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_state", a_out_state, 0);
    chk("rst_out_tag", a_out_tag, 0);
    chk("rst_b_out_valid", b_out_valid, 0);

    // Table vectors, NB=4 REG_IN=1
    for (int i = 0; i < 6; i++) begin
      xfer_a(vecs[i].mode, vecs[i].st, vecs[i].tag, gs, gt, lat);
      chk($sformatf("vec%0d_state", i), gs, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), gt, vecs[i].tag);
      chk($sformatf("vec%0d_latency", i), lat, 2);
    end

    // Random forward-then-inverse round trips
    for (int i = 0; i < 1000; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      xfer_a(2'b00, rs, i[3:0], gs, gt, lat);
      xfer_a(2'b01, gs, gt, gs2, gt2, lat2);
      chk($sformatf("roundtrip%0d", i), {gs2, gt2}, {rs, i[3:0]});
    end

    // NB=8, REG_IN=0
    @(negedge clk);
    b_in_valid = 1'b1; b_in_mode = 2'b00; b_in_tag = 4'h6; b_out_ready = 1'b1;
    b_in_state = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    @(posedge clk); #1;
    chk("nb8_fwd_valid", b_out_valid, 1);
    chk("nb8_fwd_word0", b_out_state[255:224], 32'h00050e13);
    chk("nb8_fwd_state", b_out_state,
        256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f);
    chk("nb8_fwd_tag", b_out_tag, 4'h6);
    @(negedge clk);
    b_in_mode = 2'b01; b_in_tag = 4'h7;
    b_in_state = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;
    @(posedge clk); #1;
    chk("nb8_inv_state", b_out_state,
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("nb8_inv_tag", b_out_tag, 4'h7);
    @(negedge clk);
    b_in_valid = 1'b0;

    // NB=6, REG_IN=0
    @(negedge clk);
    c_in_valid = 1'b1; c_in_mode = 2'b00; c_in_tag = 4'h2; c_out_ready = 1'b1;
    c_in_state = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    @(posedge clk); #1;
    chk("nb6_fwd_valid", c_out_valid, 1);
    chk("nb6_fwd_word0", c_out_state[191:160], 32'h00050a0f);
    chk("nb6_fwd_wordlast", c_out_state[31:0], 32'h1401060b);
    chk("nb6_fwd_state", c_out_state, 192'h00050a0f04090e13080d12170c11160310150207_1401060b);
    @(negedge clk);
    c_in_mode = 2'b01;
    c_in_state = 192'h00050a0f04090e13080d12170c1116031015020714_01060b;
    @(posedge clk); #1;
    chk("nb6_inv_state", c_out_state, 192'h000102030405060708090a0b0c0d0e0f1011121314151617);
    @(negedge clk);
    c_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("nb6_drain_valid", c_out_valid, 0);

    // Backpressure, NB=4 REG_IN=1: tags 0..7, out_ready low in cycles 3-6
    acc = 0; emit_n = 0; prev_stall = 1'b0; prev_s = '0; prev_t = '0;
    for (int cyc = 0; cyc < 40 && emit_n < 8; cyc++) begin
      @(negedge clk);
      a_in_valid = (acc < 8);
      a_in_tag = acc[3:0];
      a_in_state = {16{acc[7:0]}};
      a_in_mode = 2'b10;
      a_out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      if (prev_stall) begin
        chk($sformatf("bp_hold_state_c%0d", cyc), a_out_state, prev_s);
        chk($sformatf("bp_hold_tag_c%0d", cyc), a_out_tag, prev_t);
      end
      exp_rdy = !((acc - emit_n) == 2 && !a_out_ready);
      chk($sformatf("bp_in_ready_c%0d", cyc), a_in_ready, exp_rdy);
      acc_now = a_in_valid && a_in_ready;
      em_now = a_out_valid && a_out_ready;
      if (em_now) begin
        chk($sformatf("bp_tag_%0d", emit_n), a_out_tag, emit_n[3:0]);
        chk($sformatf("bp_state_%0d", emit_n), a_out_state, {16{emit_n[7:0]}});
        chk($sformatf("bp_cycle_%0d", emit_n), cyc, exp_cyc[emit_n]);
        emit_n++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_s = a_out_state;
      prev_t = a_out_tag;
      if (acc_now) acc++;
      @(posedge clk);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("bp_emitted", emit_n, 8);
    chk("bp_accepted", acc, 8);

    // Async reset with two states in flight
    @(negedge clk);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_mode = 2'b00; a_in_tag = 4'hc; a_in_state = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
    @(posedge clk);
    @(negedge clk);
    a_in_tag = 4'hd; a_in_state = 128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    chk("ar_pre_valid", a_out_valid, 1);
    chk("ar_pre_busy", a_busy, 1);
    chk("ar_pre_in_ready", a_in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", a_out_valid, 0);
    chk("ar_busy", a_busy, 0);
    chk("ar_out_state", a_out_state, 0);
    chk("ar_out_tag", a_out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_in_ready", a_in_ready, 1);
    xfer_a(2'b00, 128'h000102030405060708090a0b0c0d0e0f, 4'h4, gs, gt, lat);
    chk("ar_fresh_state", gs, 128'h00050a0f04090e03080d02070c01060b);
    chk("ar_fresh_tag", gt, 4'h4);
    chk("ar_fresh_latency", lat, 2);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) vcnt++;
    end
    chk("ar_no_stale", vcnt, 0);
    chk("ar_idle_busy", a_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined Rijndael ShiftRows / InvShiftRows engine for block widths Nb = 4, 6 or 8 columns (128/192/256-bit state), with a per-transaction mode select. It sits between SubBytes and MixColumns in the round datapath. It carries a sideband tag and uses valid/ready flow control on both sides, so it can be stalled by downstream round logic.

Parameters:
NB, 4, state columns; legal values 4, 6 or 8; any other value must raise an elaboration error.
REG_IN, 0, 1 adds an input register stage (latency 2); 0 gives latency 1.
TAG_W, 4, width of the sideband tag carried alongside each state.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input state valid
in_ready  out  1  block can accept input this cycle
in_mode  in  2  00 forward, 01 inverse, 10 bypass, 11 reserved (treated as bypass)
in_state  in  32*NB  state, byte k at bits [32*NB-1-8k -: 8]
in_tag  in  TAG_W  sideband tag
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
out_state  out  32*NB  transformed state
out_tag  out  TAG_W  tag of the same transaction
busy  out  1  any pipeline stage holds valid data

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Byte mapping: s[r][c] = byte 4c+r, with r in 0..3 and c in 0..NB-1.
- Row offsets: NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
- Forward: out[r][c] = in[r][(c+off[r]) mod NB].
- Inverse: out[r][(c+off[r]) mod NB] = in[r][c].
- Bypass: out = in.
- The permutation is pure wiring, applied between stages; no arithmetic.
- Pipeline: each stage is one register plus a valid bit.
- Stage advance: a stage loads when its successor is empty or its successor advances the same cycle.
- Last stage advances when out_ready=1.
- in_ready = !v_first || advance_first. It is combinational from out_ready and contains no combinational path from in_valid.
- Transfer happens when valid && ready on the same edge. With both ready, throughput is one state per cycle.
- Latency: 1 + REG_IN cycles from input accept to out_valid.
- Hold under stall: while out_valid=1 and out_ready=0, out_state and out_tag hold stable and in_ready deasserts once all stages are full.
- Full and simultaneous: when all stages are full, in_valid=1, and out_ready=1 in the same cycle, both transfers occur with no bubble.
- Empty and simultaneous: when all stages are empty and in_valid=1 with out_ready=0, the data is captured and appears after the latency, then holds.
- Mode capture: mode is captured with the data. in_mode changing while a transaction is in flight does not affect it.
- Tag: out_tag always equals the tag accepted with that state; ordering is strictly FIFO.
- Reset values: all valid bits 0, out_valid=0, busy=0, in_ready=1 after deassert, out_state=0, out_tag=0.
- Reset mid-operation: asserting rst_n low discards in-flight data immediately (asynchronous). The first accept is possible in the first cycle after deassert.
- busy = OR of all stage valid bits.

Test Plan:
- Forward, NB=4: in_state=000102030405060708090a0b0c0d0e0f, mode 00, out_ready=1 -> after 1 cycle (REG_IN=0) out_state=00050a0f04090e03080d02070c01060b, tag preserved.
- Inverse round trip, NB=4: feed the forward result with mode 01 -> 000102030405060708090a0b0c0d0e0f. Repeat with 1000 random states in forward-then-inverse order -> identity in every case.
- Forward, NB=8: bytes 00..1f -> first word 00050e13. NB=6, bytes 00..17 -> first word 00050a0f, last word 1401060b.
- Bypass and reserved modes: mode 10 and mode 11 -> out_state equals in_state exactly.
- Backpressure, REG_IN=1: stream tags 0..7 back-to-back, out_ready low for cycles 3-6 -> in_ready falls once 2 states are buffered, out_state/out_tag stable during the stall, tags emerge 0..7 in order with no loss or duplication, and one state per cycle once released.
- Async reset: assert rst_n with 2 states in flight, between clock edges -> out_valid and busy drop at once without a clock edge. After release: in_ready=1, a fresh transfer completes with latency 1+REG_IN, and no stale data appears.
